// File: rtl/lc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle LEGv8 controller:
// opcodes, state/class encodings, ALU operation codes and the control word.
package lc_ctrl_pkg;

  localparam int unsigned OPCODE_W = 11;
  localparam int unsigned STATE_W  = 3;
  localparam int unsigned CBZ_PFX_W = 8;

  localparam logic [OPCODE_W-1:0] OP_ADD  = 11'b10001011000;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 11'b11001011000;
  localparam logic [OPCODE_W-1:0] OP_AND  = 11'b10001010000;
  localparam logic [OPCODE_W-1:0] OP_ORR  = 11'b10101010000;
  localparam logic [OPCODE_W-1:0] OP_LDUR = 11'b11111000010;
  localparam logic [OPCODE_W-1:0] OP_STUR = 11'b11111000000;
  // CBZ carries part of its immediate in OPCODE[2:0]; only the prefix is fixed
  localparam logic [CBZ_PFX_W-1:0] OP_CBZ_PFX = 8'b10110100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CL_R   = 3'd0,
    CL_LD  = 3'd1,
    CL_ST  = 3'd2,
    CL_CB  = 3'd3,
    CL_ILL = 3'd4
  } iclass_e;

  typedef struct packed {
    logic       instr_read;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg2loc;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem2reg;
    logic [1:0] alu_op;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Datapath-facing bundle of the multi-cycle controller: decode inputs,
// memory handshake, unit enables and debug/status outputs.
interface multicycle_controller_if
  import lc_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);

  logic [OPCODE_W-1:0] OPCODE;
  logic                ZERO;
  logic                MEM_READY;

  logic                INSTR_READ;
  logic                IR_WRITE;
  logic                PC_WRITE;
  logic                PC_SRC;
  logic                REG2LOC;
  logic                ALU_SRC;
  logic                MEM_READ;
  logic                MEM_WRITE;
  logic                REG_WRITE;
  logic                MEM2REG;
  logic [1:0]          ALU_OP;
  logic                HALTED;
  logic [STATE_W-1:0]  STATE;
  logic [CNT_W-1:0]    RETIRED;

  // Datapath side: supplies IR bits, ALU flag and memory readiness
  modport master (
    output OPCODE, ZERO, MEM_READY,
    input  INSTR_READ, IR_WRITE, PC_WRITE, PC_SRC, REG2LOC, ALU_SRC,
           MEM_READ, MEM_WRITE, REG_WRITE, MEM2REG, ALU_OP, HALTED,
           STATE, RETIRED
  );

  // Controller side
  modport slave (
    input  OPCODE, ZERO, MEM_READY,
    output INSTR_READ, IR_WRITE, PC_WRITE, PC_SRC, REG2LOC, ALU_SRC,
           MEM_READ, MEM_WRITE, REG_WRITE, MEM2REG, ALU_OP, HALTED,
           STATE, RETIRED
  );

endinterface

// File: rtl/opcode_class_decode.sv
// Combinational LEGv8 opcode classifier (R / LD / ST / CB / ILL); shared
// between the multi-cycle controller and the single-cycle Controller.
module opcode_class_decode
  import lc_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode_i,
  output iclass_e             class_o
);

  always_comb begin
    class_o = CL_ILL;
    if (opcode_i[OPCODE_W-1 -: CBZ_PFX_W] == OP_CBZ_PFX) begin
      class_o = CL_CB;
    end else begin
      case (opcode_i)
        OP_ADD, OP_SUB, OP_AND, OP_ORR: class_o = CL_R;
        OP_LDUR:                        class_o = CL_LD;
        OP_STUR:                        class_o = CL_ST;
        default:                        class_o = CL_ILL;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multi-cycle LEGv8 datapath: steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB and counts retirements.
module multicycle_controller
  import lc_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
)(
  input  logic                    CLK,
  input  logic                    RESET_N,
  multicycle_controller_if.slave  bus
);

  state_e           state_q;
  iclass_e          class_q;
  iclass_e          dec_class;
  logic             armed_q;
  logic [CNT_W-1:0] retired_q;
  ctrl_t            ctrl;

  opcode_class_decode u_decode (
    .opcode_i (bus.OPCODE),
    .class_o  (dec_class)
  );

  // State, class and retirement counter. The first edge after reset release
  // only arms the sequencer, so IDLE spans one full clock cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      class_q   <= CL_R;
      armed_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      armed_q <= 1'b1;
      if (ctrl.pc_write) begin
        retired_q <= retired_q + CNT_W'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (armed_q) state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          if (bus.MEM_READY) state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          class_q <= dec_class;
          state_q <= (dec_class == CL_ILL) ? ST_HALT : ST_EXEC;
        end
        ST_EXEC: begin
          case (class_q)
            CL_R:         state_q <= ST_WB;
            CL_LD, CL_ST: state_q <= ST_MEM;
            CL_CB:        state_q <= ST_FETCH;
            default:      state_q <= ST_HALT;
          endcase
        end
        ST_MEM: begin
          if (bus.MEM_READY) begin
            state_q <= (class_q == CL_LD) ? ST_WB : ST_FETCH;
          end
        end
        ST_WB:   state_q <= ST_FETCH;
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Control decode from state and class. In DECODE the class register is
  // not loaded yet, so REG2LOC comes straight from the decoded opcode.
  always_comb begin
    ctrl = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl.instr_read = 1'b1;
        ctrl.ir_write   = bus.MEM_READY;
      end
      ST_DECODE: begin
        ctrl.reg2loc = (dec_class == CL_ST) || (dec_class == CL_CB);
      end
      ST_EXEC: begin
        ctrl.reg2loc = (class_q == CL_ST) || (class_q == CL_CB);
        ctrl.alu_src = (class_q == CL_LD) || (class_q == CL_ST);
        case (class_q)
          CL_R:    ctrl.alu_op = ALUOP_RTYPE;
          CL_CB: begin
            ctrl.alu_op   = ALUOP_PASSB;
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = bus.ZERO;
          end
          default: ctrl.alu_op = ALUOP_ADD;
        endcase
      end
      ST_MEM: begin
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.mem_read  = (class_q == CL_LD);
        ctrl.mem_write = (class_q == CL_ST);
        ctrl.pc_write  = (class_q == CL_ST) && bus.MEM_READY;
      end
      ST_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem2reg   = (class_q == CL_LD);
        ctrl.pc_write  = 1'b1;
      end
      ST_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.INSTR_READ = ctrl.instr_read;
  assign bus.IR_WRITE   = ctrl.ir_write;
  assign bus.PC_WRITE   = ctrl.pc_write;
  assign bus.PC_SRC     = ctrl.pc_src;
  assign bus.REG2LOC    = ctrl.reg2loc;
  assign bus.ALU_SRC    = ctrl.alu_src;
  assign bus.MEM_READ   = ctrl.mem_read;
  assign bus.MEM_WRITE  = ctrl.mem_write;
  assign bus.REG_WRITE  = ctrl.reg_write;
  assign bus.MEM2REG    = ctrl.mem2reg;
  assign bus.ALU_OP     = ctrl.alu_op;
  assign bus.HALTED     = ctrl.halted;
  assign bus.STATE      = state_q;
  assign bus.RETIRED    = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control
// words are queued as stimulus is driven and checked at the falling edge.
module tb_multicycle_controller;

  localparam int unsigned CNT_W = 2;

  // state, instr_read..mem2reg (10 flags), alu_op, halted, retired
  typedef struct packed {
    logic [2:0]       st;
    logic [9:0]       f;
    logic [1:0]       aop;
    logic             h;
    logic [CNT_W-1:0] ret;
  } exp_t;

  typedef struct packed {
    logic        rdy;
    logic        zero;
    logic [10:0] op;
    exp_t        e;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   errors  = 0;
  logic [CNT_W-1:0] ret_exp = '0;
  exp_t sb_q[$];

  multicycle_controller_if #(.CNT_W(CNT_W)) bus ();

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;

  function automatic stim_t sv(input logic rdy, input logic z, input logic [10:0] op,
                               input logic [2:0] st, input logic [9:0] f,
                               input logic [1:0] aop, input logic h);
    stim_t s;
    s.rdy   = rdy;
    s.zero  = z;
    s.op    = op;
    s.e.st  = st;
    s.e.f   = f;
    s.e.aop = aop;
    s.e.h   = h;
    s.e.ret = '0;
    return s;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.st  = bus.STATE;
    o.f   = {bus.INSTR_READ, bus.IR_WRITE, bus.PC_WRITE, bus.PC_SRC, bus.REG2LOC,
             bus.ALU_SRC, bus.MEM_READ, bus.MEM_WRITE, bus.REG_WRITE, bus.MEM2REG};
    o.aop = bus.ALU_OP;
    o.h   = bus.HALTED;
    o.ret = bus.RETIRED;
    return o;
  endfunction

  // Drive one stimulus entry and queue its expectation (retire count modelled here)
  task automatic drive(input stim_t s);
    exp_t e;
    bus.MEM_READY = s.rdy;
    bus.ZERO      = s.zero;
    bus.OPCODE    = s.op;
    e     = s.e;
    e.ret = ret_exp;
    sb_q.push_back(e);
    if (e.f[7]) ret_exp = ret_exp + CNT_W'(1);
  endtask

  // Leaves the bench #1 after the edge that enters the first FETCH
  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    ret_exp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t seq[$];
    exp_t  got, e;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) seq.push_back(sv(1, 0, ADD, 3'd0, 10'b0, 2'b00, 0));
    seq.push_back(sv(1, 0, ADD, 3'd1, 10'b1100000000, 2'b00, 0));
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk);
      got = observe();
      e   = sb_q.pop_front();
      vectors++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset cyc%0d got=%h exp=%h", i, got, e);
      end
      if (i == 2) rst_n = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_add();
    stim_t seq[$];
    exp_t  got, e;
    do_reset();
    seq.push_back(sv(1, 0, ADD, 3'd1, 10'b1100000000, 2'b00, 0));
    seq.push_back(sv(1, 0, ADD, 3'd2, 10'b0000000000, 2'b00, 0));
    seq.push_back(sv(1, 0, ADD, 3'd3, 10'b0000000000, 2'b10, 0));
    seq.push_back(sv(1, 0, ADD, 3'd5, 10'b0010000010, 2'b00, 0));
    seq.push_back(sv(1, 0, ADD, 3'd1, 10'b1100000000, 2'b00, 0));
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk);
      got = observe();
      e   = sb_q.pop_front();
      vectors++;
      if (got !== e) begin
        errors++;
        $display("FAIL add cyc%0d got=%h exp=%h", i, got, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_ldur_stall();
    stim_t seq[$];
    exp_t  got, e;
    do_reset();
    seq.push_back(sv(1, 0, LDUR, 3'd1, 10'b1100000000, 2'b00, 0));
    seq.push_back(sv(1, 0, LDUR, 3'd2, 10'b0000000000, 2'b00, 0));
    seq.push_back(sv(1, 0, LDUR, 3'd3, 10'b0000010000, 2'b00, 0));
    seq.push_back(sv(0, 0, LDUR, 3'd4, 10'b0000011000, 2'b00, 0));
    seq.push_back(sv(0, 1, LDUR, 3'd4, 10'b0000011000, 2'b00, 0));
    seq.push_back(sv(1, 0, LDUR, 3'd4, 10'b0000011000, 2'b00, 0));
    seq.push_back(sv(1, 0, LDUR, 3'd5, 10'b0010000011, 2'b00, 0));
    seq.push_back(sv(1, 0, LDUR, 3'd1, 10'b1100000000, 2'b00, 0));
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk);
      got = observe();
      e   = sb_q.pop_front();
      vectors++;
      if (got !== e) begin
        errors++;
        $display("FAIL ldur cyc%0d got=%h exp=%h", i, got, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_cbz();
    stim_t seq[$];
    exp_t  got, e;
    logic [10:0] cb_a, cb_b;
    cb_a = 11'b10110100101;
    cb_b = 11'b10110100010;
    do_reset();
    seq.push_back(sv(1, 1, cb_a, 3'd1, 10'b1100000000, 2'b00, 0));
    seq.push_back(sv(1, 1, cb_a, 3'd2, 10'b0000100000, 2'b00, 0));
    seq.push_back(sv(1, 1, cb_a, 3'd3, 10'b0011100000, 2'b01, 0));
    seq.push_back(sv(1, 0, cb_b, 3'd1, 10'b1100000000, 2'b00, 0));
    seq.push_back(sv(1, 0, cb_b, 3'd2, 10'b0000100000, 2'b00, 0));
    seq.push_back(sv(1, 0, cb_b, 3'd3, 10'b0010100000, 2'b01, 0));
    seq.push_back(sv(1, 0, cb_b, 3'd1, 10'b1100000000, 2'b00, 0));
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk);
      got = observe();
      e   = sb_q.pop_front();
      vectors++;
      if (got !== e) begin
        errors++;
        $display("FAIL cbz cyc%0d got=%h exp=%h", i, got, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_stur_reset();
    stim_t seq[$];
    exp_t  got, e;
    do_reset();
    seq.push_back(sv(0, 0, STUR, 3'd1, 10'b1000000000, 2'b00, 0));
    seq.push_back(sv(1, 0, STUR, 3'd1, 10'b1100000000, 2'b00, 0));
    seq.push_back(sv(1, 0, STUR, 3'd2, 10'b0000100000, 2'b00, 0));
    seq.push_back(sv(1, 0, STUR, 3'd3, 10'b0000110000, 2'b00, 0));
    seq.push_back(sv(0, 0, STUR, 3'd4, 10'b0000010100, 2'b00, 0));
    seq.push_back(sv(1, 0, STUR, 3'd4, 10'b0010010100, 2'b00, 0));
    seq.push_back(sv(1, 0, STUR, 3'd1, 10'b1100000000, 2'b00, 0));
    seq.push_back(sv(1, 0, STUR, 3'd2, 10'b0000100000, 2'b00, 0));
    seq.push_back(sv(1, 0, STUR, 3'd3, 10'b0000110000, 2'b00, 0));
    seq.push_back(sv(0, 0, STUR, 3'd4, 10'b0000010100, 2'b00, 0));
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk);
      got = observe();
      e   = sb_q.pop_front();
      vectors++;
      if (got !== e) begin
        errors++;
        $display("FAIL stur cyc%0d got=%h exp=%h", i, got, e);
      end
      @(posedge clk);
      #1;
    end
    // Still in MEM with MEM_WRITE high: reset between edges must clear everything
    #2;
    ret_exp = '0;
    drive(sv(0, 0, STUR, 3'd0, 10'b0000000000, 2'b00, 0));
    rst_n = 1'b0;
    #1;
    got = observe();
    e   = sb_q.pop_front();
    vectors++;
    if (got !== e) begin
      errors++;
      $display("FAIL stur_async_reset got=%h exp=%h", got, e);
    end
  endtask

  task automatic test_illegal();
    stim_t seq[$];
    exp_t  got, e;
    do_reset();
    seq.push_back(sv(1, 0, 11'b0, 3'd1, 10'b1100000000, 2'b00, 0));
    seq.push_back(sv(1, 0, 11'b0, 3'd2, 10'b0000000000, 2'b00, 0));
    for (int k = 0; k < 10; k++) seq.push_back(sv(1, 0, ADD, 3'd6, 10'b0, 2'b00, 1));
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk);
      got = observe();
      e   = sb_q.pop_front();
      vectors++;
      if (got !== e) begin
        errors++;
        $display("FAIL illegal cyc%0d got=%h exp=%h", i, got, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back_wrap();
    stim_t seq[$];
    exp_t  got, e;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      seq.push_back(sv(1, 0, ADD, 3'd1, 10'b1100000000, 2'b00, 0));
      seq.push_back(sv(1, 0, ADD, 3'd2, 10'b0000000000, 2'b00, 0));
      seq.push_back(sv(1, 0, ADD, 3'd3, 10'b0000000000, 2'b10, 0));
      seq.push_back(sv(1, 0, ADD, 3'd5, 10'b0010000010, 2'b00, 0));
    end
    seq.push_back(sv(1, 0, ADD, 3'd1, 10'b1100000000, 2'b00, 0));
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk);
      got = observe();
      e   = sb_q.pop_front();
      vectors++;
      if (got !== e) begin
        errors++;
        $display("FAIL wrap cyc%0d got=%h exp=%h", i, got, e);
      end
      @(posedge clk);
      #1;
    end
    vectors++;
    if (bus.RETIRED !== 2'd1) begin
      errors++;
      $display("FAIL wrap_final got=%0d exp=1", bus.RETIRED);
    end
  endtask

  initial begin
    bus.OPCODE    = ADD;
    bus.ZERO      = 1'b0;
    bus.MEM_READY = 1'b1;
    test_reset();
    test_add();
    test_ldur_stall();
    test_cbz();
    test_stur_reset();
    test_illegal();
    test_back_to_back_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style sequencing FSM for the multi-cycle LEGv8 datapath. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK so that one ALU, one data memory port and one register file are reused across cycles. It sits beside the existing `Controller`, `ALU`, `DATA_MEM` and `REG_MEM` units and drives their enables. It stalls on a memory-ready handshake and counts retired instructions.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RESET_N` input 1: reset, asynchronous and active-low.
- `OPCODE` input 11: `IR[31:21]`. Sampled only in DECODE.
- `ZERO` input 1: ALU zero flag. Sampled only in EXECUTE.
- `MEM_READY` input 1: instruction/data memory completes the access this cycle.
- `INSTR_READ` output 1: instruction memory read request.
- `IR_WRITE` output 1: load the instruction register.
- `PC_WRITE` output 1: update the PC.
- `PC_SRC` output 1: 1 selects the branch target, 0 selects PC+4.
- `REG2LOC` output 1
- `ALU_SRC` output 1
- `MEM_READ` output 1
- `MEM_WRITE` output 1
- `REG_WRITE` output 1
- `MEM2REG` output 1
- `ALU_OP` output 2: 00 add, 01 pass-B/zero-test, 10 R-type funct.
- `HALTED` output 1: an illegal opcode was seen.
- `STATE` output 3: current state, for debug.
- `RETIRED` output `CNT_W`: retired-instruction count.

## Operation
- **Instruction classes**, latched into a class register in DECODE:
  - R: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - LD: LDUR 11111000010.
  - ST: STUR 11111000000.
  - CB: CBZ, `OPCODE[10:3]`=10110100, `OPCODE[2:0]` ignored.
  - Anything else is ILL.
- **States and encodings:** IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- **IDLE**
  - All outputs 0.
  - Goes to FETCH on the next edge, unconditionally.
- **FETCH**
  - `INSTR_READ`=1.
  - If `MEM_READY`=0: hold.
  - If `MEM_READY`=1: `IR_WRITE`=1 in the same cycle; go to DECODE.
- **DECODE**
  - `REG2LOC`=1 for ST and CB, else 0.
  - Latch the class; ILL goes to HALT, every other class goes to EXEC.
- **EXEC**
  - `ALU_OP`: R=10, LD/ST=00, CB=01.
  - `ALU_SRC`: 1 for LD/ST, 0 for R/CB.
  - `REG2LOC` stays as set in DECODE.
  - CB: `PC_WRITE`=1 and `PC_SRC`=`ZERO`; go to FETCH.
  - R goes to WB; LD/ST go to MEM.
- **MEM**
  - LD: `MEM_READ`=1. ST: `MEM_WRITE`=1. `ALU_SRC`=1 and `ALU_OP`=00 stay asserted.
  - Hold while `MEM_READY`=0.
  - On ready, LD goes to WB.
  - On ready, ST asserts `PC_WRITE`=1 (`PC_SRC`=0) and goes to FETCH.
- **WB**
  - `REG_WRITE`=1; `MEM2REG`=1 for LD, else 0.
  - `PC_WRITE`=1, `PC_SRC`=0; go to FETCH.
- **HALT**
  - All control outputs 0, `HALTED`=1.
  - Stays until reset.
- **RETIRED**
  - Increments by 1 on every cycle where `PC_WRITE`=1.
  - Wraps modulo 2^`CNT_W`.
- **Output decode:** outputs are combinational from the state register and the class register only. No path from `MEM_READY` to outputs except `IR_WRITE` and `PC_WRITE` in MEM. No path from `ZERO` except `PC_SRC`.

## Timing
- **Reset:**
  - Asserting `RESET_N` low at any time, including mid-MEM with `MEM_WRITE` high, immediately forces state IDLE, class R, `RETIRED`=0.
  - This drops every output to 0 asynchronously.
- **First request:** after reset release, IDLE lasts exactly one cycle, and `INSTR_READ` rises at the second rising edge after release.
- **Latency** with `MEM_READY` tied high, FETCH to the next FETCH:
  - R: 4 cycles.
  - LD: 5 cycles.
  - ST: 4 cycles.
  - CB: 3 cycles.
- **Stalls:** each `MEM_READY`=0 cycle in FETCH or MEM adds exactly one cycle. The request and control outputs stay stable throughout the stall.
- **Pulse widths:** `IR_WRITE` and `PC_WRITE` are high for exactly one cycle per instruction.
- **Mutual exclusion:** `MEM_READ` and `MEM_WRITE` are never high together, and never high outside MEM.

## Structure
- **Package `lc_ctrl_pkg`:**
  - Opcode constants (ADD, SUB, AND, ORR, LDUR, STUR, CBZ prefix).
  - State enum with the encodings above.
  - Class enum (R, LD, ST, CB, ILL).
  - `ALU_OP` codes.
- **Sub-module `opcode_class_decode`:** combinational, 11-bit opcode in, class out. It is also reusable by the single-cycle `Controller`.

## Test plan
- **Reset and first fetch:** hold `RESET_N`=0 for 3 cycles, then release with `MEM_READY`=1.
  - During reset: all outputs 0, `STATE`=0.
  - `INSTR_READ`=1 exactly 2 edges after release.
- **ADD retire:** `OPCODE`=10001011000, `MEM_READY`=1.
  - `STATE` sequence 1,2,3,5,1.
  - `ALU_OP`=10 in EXEC; `REG_WRITE`=1 and `PC_WRITE`=1 in WB.
  - `RETIRED` goes 0 to 1.
- **LDUR with stall:** `OPCODE`=11111000010, `MEM_READY` low for 2 cycles in MEM.
  - MEM lasts 3 cycles with `MEM_READ`=1 and `ALU_SRC`=1.
  - WB has `MEM2REG`=1.
  - Total FETCH-to-FETCH is 7 cycles.
- **CBZ both ways:** `OPCODE`=10110100xxx.
  - `ZERO`=1 gives `PC_SRC`=1 with `PC_WRITE`=1 in EXEC.
  - `ZERO`=0 gives `PC_SRC`=0.
  - Both take 3 cycles; `REG2LOC`=1 in DECODE and EXEC.
- **STUR interrupted by reset:** pull `RESET_N` low while in MEM with `MEM_WRITE`=1.
  - `MEM_WRITE` drops with no clock edge.
  - `RETIRED`=0; state IDLE.
- **Illegal opcode and counter wrap:**
  - `OPCODE`=00000000000 leads to HALT, `HALTED`=1, and no further `INSTR_READ` for 10 cycles.
  - With `CNT_W`=2, the fifth retired ADD returns `RETIRED` to 1.
